// File: rtl/ddr_cmd_pkg.sv
// Shared types and helpers for the DDR4 command/address bus decoder.
package ddr_cmd_pkg;

    localparam int NUM_BANKS  = 16;
    localparam int ROW_W      = 14;
    localparam int COL_W      = 10;
    // Storage width for per-bank timing counters; holds any CNT_W up to 8.
    localparam int BANK_CNT_W = 8;

    typedef enum logic [3:0] {
        CMD_DES  = 4'd0,
        CMD_NOP  = 4'd1,
        CMD_ACT  = 4'd2,
        CMD_RD   = 4'd3,
        CMD_WR   = 4'd4,
        CMD_PRE  = 4'd5,
        CMD_PREA = 4'd6,
        CMD_REF  = 4'd7,
        CMD_MRS  = 4'd8,
        CMD_ZQC  = 4'd9,
        CMD_RFU  = 4'd10
    } ddr_cmd_e;

    // Lower numeric value wins when several apply (V_NONE means clean).
    typedef enum logic [2:0] {
        V_NONE     = 3'd0,
        V_RFU      = 3'd1,
        V_ACT_OPEN = 3'd2,
        V_TRP      = 3'd3,
        V_CLOSED   = 3'd4,
        V_TRCD     = 3'd5,
        V_TRAS     = 3'd6,
        V_REF_OPEN = 3'd7
    } ddr_viol_e;

    typedef struct packed {
        logic                  open;
        logic [ROW_W-1:0]      row;
        logic [BANK_CNT_W-1:0] rcd_cnt;
        logic [BANK_CNT_W-1:0] rp_cnt;
        logic [BANK_CNT_W-1:0] ras_cnt;
    } bank_state_t;

    // Down-count that sticks at zero.
    function automatic logic [BANK_CNT_W-1:0] sat_dec(input logic [BANK_CNT_W-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - BANK_CNT_W'(1);
    endfunction

    // Command truth table for a selected, clock-enabled cycle.
    function automatic ddr_cmd_e decode_cmd(input logic act_n, input logic ras_n,
                                            input logic cas_n, input logic we_n,
                                            input logic a10);
        ddr_cmd_e c;
        if (!act_n) begin
            c = CMD_ACT;
        end else begin
            case ({ras_n, cas_n, we_n})
                3'b000:  c = CMD_MRS;
                3'b001:  c = CMD_REF;
                3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
                3'b011:  c = CMD_RFU;
                3'b100:  c = CMD_WR;
                3'b101:  c = CMD_RD;
                3'b110:  c = CMD_ZQC;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Per-bank state: open flag, open row and the tRCD/tRP/tRAS down-counters.
// Reports which timing windows have expired; the decoder judges legality.
module ddr_bank_tracker
    import ddr_cmd_pkg::*;
#(
    parameter int T_RCD = 11,
    parameter int T_RP  = 11,
    parameter int T_RAS = 28,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_act,
    input  logic             i_close,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_open,
    output logic             o_rcd_ok,
    output logic             o_rp_ok,
    output logic             o_ras_ok
);

    // Reload values are one less than the constraint: the check looks at the
    // value before the edge, so N-1 reaches zero exactly N cycles later.
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);

    bank_state_t r_state;
    bank_state_t w_next;

    // Next state: counters always run down; ACT/close override them.
    always_comb begin
        w_next         = r_state;
        w_next.rcd_cnt = sat_dec(r_state.rcd_cnt);
        w_next.rp_cnt  = sat_dec(r_state.rp_cnt);
        w_next.ras_cnt = sat_dec(r_state.ras_cnt);
        if (i_act) begin
            // A re-ACT of an open bank keeps the row it already holds.
            if (!r_state.open) begin
                w_next.row = i_row;
            end
            w_next.open    = 1'b1;
            w_next.rcd_cnt = BANK_CNT_W'(RCD_LD);
            w_next.ras_cnt = BANK_CNT_W'(RAS_LD);
        end else if (i_close) begin
            w_next.open   = 1'b0;
            w_next.rp_cnt = BANK_CNT_W'(RP_LD);
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_open   = r_state.open;
    assign o_rcd_ok = (r_state.rcd_cnt == '0);
    assign o_rp_ok  = (r_state.rp_cnt == '0);
    assign o_ras_ok = (r_state.ras_cnt == '0);

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DRAM-side DDR4 command decoder: samples the CA pins, decodes the command
// one cycle later, tracks all bank states and flags timing violations.
module ddr_cmd_decoder
    import ddr_cmd_pkg::*;
#(
    parameter int T_RCD = 11,
    parameter int T_RP  = 11,
    parameter int T_RAS = 28,
    parameter int CNT_W = 6
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        CKE,
    input  logic        cs_n,
    input  logic        act_n,
    input  logic        RAS_n_A16,
    input  logic        CAS_n_A15,
    input  logic        WE_n_A14,
    input  logic [1:0]  bg_addr,
    input  logic [1:0]  ba_addr,
    input  logic        A17,
    input  logic        A13,
    input  logic        A12_BC_n,
    input  logic        A11,
    input  logic        A10_AP,
    input  logic [9:0]  A9_A0,
    output logic        cmd_valid,
    output logic [3:0]  cmd_type,
    output logic [3:0]  cmd_bank,
    output logic [13:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        cmd_ap,
    output logic        cmd_bc_n,
    output logic [15:0] bank_open,
    output logic        viol_valid,
    output logic [2:0]  viol_code
);

    // A17 carries no meaning for the commands decoded here.
    logic w_unused_a17;
    assign w_unused_a17 = A17;

    logic             r_cke, r_cs_n, r_act_n, r_ras_n, r_cas_n, r_we_n;
    logic [3:0]       r_bank;
    logic [ROW_W-1:0] r_addr;

    ddr_cmd_e  w_cmd;
    ddr_viol_e w_viol;
    logic      w_close_one;
    logic [NUM_BANKS-1:0] w_sel, w_act, w_close;
    logic [NUM_BANKS-1:0] w_open, w_rcd_ok, w_rp_ok, w_ras_ok;

    // Pin capture stage: every CA pin is registered on the rising edge.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_cke   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_act_n <= 1'b1;
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_we_n  <= 1'b1;
            r_bank  <= '0;
            r_addr  <= '0;
        end else begin
            r_cke   <= CKE;
            r_cs_n  <= cs_n;
            r_act_n <= act_n;
            r_ras_n <= RAS_n_A16;
            r_cas_n <= CAS_n_A15;
            r_we_n  <= WE_n_A14;
            r_bank  <= {bg_addr, ba_addr};
            r_addr  <= {A13, A12_BC_n, A11, A10_AP, A9_A0};
        end
    end

    // Decode and per-bank control: unselected or clock-gated cycles are DES.
    always_comb begin
        w_cmd = CMD_DES;
        if (r_cke && !r_cs_n) begin
            w_cmd = decode_cmd(r_act_n, r_ras_n, r_cas_n, r_we_n, r_addr[10]);
        end
        w_sel       = NUM_BANKS'(1) << r_bank;
        w_close_one = (w_cmd == CMD_PRE) ||
                      (((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && r_addr[10]);
        w_act       = w_sel & {NUM_BANKS{w_cmd == CMD_ACT}};
        w_close     = (w_cmd == CMD_PREA) ? '1 : (w_sel & {NUM_BANKS{w_close_one}});
    end

    // Legality against the bank state as it stood before this edge.
    always_comb begin
        w_viol = V_NONE;
        case (w_cmd)
            CMD_RFU: w_viol = V_RFU;
            CMD_ACT: begin
                if (w_open[r_bank])        w_viol = V_ACT_OPEN;
                else if (!w_rp_ok[r_bank]) w_viol = V_TRP;
            end
            CMD_RD, CMD_WR: begin
                if (!w_open[r_bank])        w_viol = V_CLOSED;
                else if (!w_rcd_ok[r_bank]) w_viol = V_TRCD;
            end
            CMD_PRE: begin
                if (w_open[r_bank] && !w_ras_ok[r_bank]) w_viol = V_TRAS;
            end
            CMD_PREA: begin
                if (|(w_open & ~w_ras_ok)) w_viol = V_TRAS;
            end
            CMD_REF: begin
                if (|w_open) w_viol = V_REF_OPEN;
            end
            default: w_viol = V_NONE;
        endcase
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ddr_bank_tracker #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .CNT_W (CNT_W)
        ) u_bank (
            .i_clk    (CK_t),
            .i_rst_n  (reset_n),
            .i_act    (w_act[g]),
            .i_close  (w_close[g]),
            .i_row    (r_addr),
            .o_open   (w_open[g]),
            .o_rcd_ok (w_rcd_ok[g]),
            .o_rp_ok  (w_rp_ok[g]),
            .o_ras_ok (w_ras_ok[g])
        );
    end

    assign bank_open = w_open;

    // Output stage: decoded command and violation, updated with bank state.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid  <= 1'b0;
            cmd_type   <= CMD_DES;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            cmd_ap     <= 1'b0;
            cmd_bc_n   <= 1'b0;
            viol_valid <= 1'b0;
            viol_code  <= V_NONE;
        end else begin
            cmd_valid  <= (w_cmd != CMD_DES) && (w_cmd != CMD_NOP);
            cmd_type   <= w_cmd;
            cmd_bank   <= r_bank;
            cmd_row    <= r_addr;
            cmd_col    <= r_addr[COL_W-1:0];
            cmd_ap     <= r_addr[10];
            cmd_bc_n   <= r_addr[12];
            viol_valid <= (w_viol != V_NONE);
            viol_code  <= w_viol;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed bench for ddr_cmd_decoder: a per-cycle vector table with
// hand-computed expectations, plus a hand-written mid-operation reset.
module tb_ddr_cmd_decoder;

    localparam logic [3:0] C_DES = 4'd0, C_NOP = 4'd1, C_ACT = 4'd2, C_RD = 4'd3,
                           C_WR = 4'd4, C_PRE = 4'd5, C_PREA = 4'd6, C_REF = 4'd7,
                           C_MRS = 4'd8, C_ZQC = 4'd9, C_RFU = 4'd10;
    localparam logic [2:0] V_OK = 3'd0, V_RFU = 3'd1, V_ACT_OPEN = 3'd2, V_TRP = 3'd3,
                           V_CLOSED = 3'd4, V_TRCD = 3'd5, V_TRAS = 3'd6, V_REF_OPEN = 3'd7;

    logic        CK_t, reset_n, CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [1:0]  bg_addr, ba_addr;
    logic        A17, A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic        cmd_valid, cmd_ap, cmd_bc_n, viol_valid;
    logic [3:0]  cmd_type, cmd_bank;
    logic [13:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [15:0] bank_open;
    logic [2:0]  viol_code;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        cke, cs_n, act_n, ras, cas, we;
        logic [3:0]  bank;
        logic [13:0] addr;
        logic        ev;
        logic [3:0]  et;
        logic [2:0]  evi;
        logic [15:0] eopen;
    } vec_t;

    vec_t tbl[$];

    ddr_cmd_decoder dut (
        .CK_t(CK_t), .reset_n(reset_n), .CKE(CKE), .cs_n(cs_n), .act_n(act_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .bg_addr(bg_addr), .ba_addr(ba_addr), .A17(A17), .A13(A13),
        .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap), .cmd_bc_n(cmd_bc_n),
        .bank_open(bank_open), .viol_valid(viol_valid), .viol_code(viol_code)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    function automatic vec_t des_vec(input logic [15:0] op);
        vec_t v;
        v.cke = 1'b1; v.cs_n = 1'b1; v.act_n = 1'b1;
        v.ras = 1'b1; v.cas = 1'b1; v.we = 1'b1;
        v.bank = 4'd0; v.addr = 14'd0;
        v.ev = 1'b0; v.et = C_DES; v.evi = V_OK; v.eopen = op;
        return v;
    endfunction

    function automatic vec_t cmd_vec(input logic [3:0] c, input logic [3:0] b,
                                     input logic [13:0] a, input logic [2:0] evi,
                                     input logic [15:0] op);
        vec_t v;
        v = des_vec(op);
        v.cs_n = 1'b0; v.bank = b; v.addr = a;
        case (c)
            C_ACT:  v.act_n = 1'b0;
            C_RD:   {v.ras, v.cas, v.we} = 3'b101;
            C_WR:   {v.ras, v.cas, v.we} = 3'b100;
            C_PRE:  begin {v.ras, v.cas, v.we} = 3'b010; v.addr[10] = 1'b0; end
            C_PREA: begin {v.ras, v.cas, v.we} = 3'b010; v.addr[10] = 1'b1; end
            C_REF:  {v.ras, v.cas, v.we} = 3'b001;
            C_MRS:  {v.ras, v.cas, v.we} = 3'b000;
            C_ZQC:  {v.ras, v.cas, v.we} = 3'b110;
            C_RFU:  {v.ras, v.cas, v.we} = 3'b011;
            default: {v.ras, v.cas, v.we} = 3'b111;
        endcase
        v.ev = (c != C_NOP); v.et = c; v.evi = evi;
        return v;
    endfunction

    task automatic add_cmd(input logic [3:0] c, input logic [3:0] b, input logic [13:0] a,
                           input logic [2:0] evi, input logic [15:0] op);
        tbl.push_back(cmd_vec(c, b, a, evi, op));
    endtask

    task automatic add_des(input int n, input logic [15:0] op);
        for (int k = 0; k < n; k++) tbl.push_back(des_vec(op));
    endtask

    // Drive one cycle's pins at the falling edge, ahead of the sampling edge.
    task automatic drive(input vec_t v);
        @(negedge CK_t);
        CKE = v.cke; cs_n = v.cs_n; act_n = v.act_n;
        RAS_n_A16 = v.ras; CAS_n_A15 = v.cas; WE_n_A14 = v.we;
        {bg_addr, ba_addr} = v.bank;
        {A13, A12_BC_n, A11, A10_AP, A9_A0} = v.addr;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic ok;
        ok = (cmd_valid === v.ev) && (cmd_type === v.et) && (viol_code === v.evi) &&
             (viol_valid === (v.evi != V_OK)) && (bank_open === v.eopen);
        if (v.ev && (cmd_bank !== v.bank)) ok = 1'b0;
        if (v.ev && (v.et == C_ACT) && (cmd_row !== v.addr)) ok = 1'b0;
        if (v.ev && ((v.et == C_RD) || (v.et == C_WR)) &&
            ((cmd_col !== v.addr[9:0]) || (cmd_ap !== v.addr[10]) || (cmd_bc_n !== v.addr[12])))
            ok = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL vec%0d: got valid=%0b type=%0d bank=%0d row=%h col=%h ap=%0b viol=%0b/%0d open=%h; expected valid=%0b type=%0d bank=%0d addr=%h viol=%0d open=%h",
                      idx, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_ap,
                      viol_valid, viol_code, bank_open, v.ev, v.et, v.bank, v.addr, v.evi, v.eopen);
    endtask

    initial begin
        reset_n = 1'b1; CKE = 1'b1; cs_n = 1'b1; act_n = 1'b1;
        RAS_n_A16 = 1'b1; CAS_n_A15 = 1'b1; WE_n_A14 = 1'b1;
        bg_addr = 2'd0; ba_addr = 2'd0; A17 = 1'b0; A13 = 1'b0;
        A12_BC_n = 1'b0; A11 = 1'b0; A10_AP = 1'b0; A9_A0 = 10'd0;

        // Normal ACT -> RD after exactly tRCD.
        add_cmd(C_ACT, 4'd5, 14'h01A3, V_OK, 16'h0020);
        add_des(10, 16'h0020);
        add_cmd(C_RD, 4'd5, 14'h0040, V_OK, 16'h0020);
        // Bank 2 timeline, cycle numbers relative to its ACT.
        add_cmd(C_ACT, 4'd2, 14'h0055, V_OK, 16'h0024);        // 0
        add_des(4, 16'h0024);
        add_cmd(C_RD, 4'd2, 14'h0010, V_TRCD, 16'h0024);       // 5
        add_des(4, 16'h0024);
        add_cmd(C_PRE, 4'd2, 14'h0000, V_TRAS, 16'h0020);      // 10
        add_des(17, 16'h0020);
        add_cmd(C_PREA, 4'd0, 14'h0000, V_OK, 16'h0000);       // 28
        add_des(6, 16'h0000);
        add_cmd(C_ACT, 4'd2, 14'h0077, V_TRP, 16'h0004);       // 35
        add_des(3, 16'h0004);
        add_cmd(C_ACT, 4'd0, 14'h0100, V_OK, 16'h0005);        // 39: tRP just met
        add_cmd(C_ACT, 4'd5, 14'h0200, V_OK, 16'h0025);        // 40
        add_cmd(C_PRE, 4'd2, 14'h0000, V_TRAS, 16'h0021);      // 41
        add_cmd(C_REF, 4'd0, 14'h0000, V_REF_OPEN, 16'h0021);  // 42
        add_des(25, 16'h0021);
        add_cmd(C_PREA, 4'd0, 14'h0000, V_OK, 16'h0000);       // 68: tRAS of bank 5 just met
        add_cmd(C_REF, 4'd0, 14'h0000, V_OK, 16'h0000);
        add_cmd(C_MRS, 4'd0, 14'h0000, V_OK, 16'h0000);
        add_cmd(C_ZQC, 4'd0, 14'h0000, V_OK, 16'h0000);
        add_cmd(C_RFU, 4'd0, 14'h0000, V_RFU, 16'h0000);
        add_cmd(C_NOP, 4'd0, 14'h0000, V_OK, 16'h0000);
        add_cmd(C_RD, 4'd3, 14'h0020, V_CLOSED, 16'h0000);
        add_cmd(C_WR, 4'd1, 14'h0400, V_CLOSED, 16'h0000);
        // CKE low with ACT pins, then deselected ACT pins: nothing decoded.
        tbl.push_back(cmd_vec(C_ACT, 4'd4, 14'h0ABC, V_OK, 16'h0000));
        tbl[tbl.size()-1].cke = 1'b0; tbl[tbl.size()-1].ev = 1'b0; tbl[tbl.size()-1].et = C_DES;
        tbl.push_back(cmd_vec(C_ACT, 4'd4, 14'h0ABC, V_OK, 16'h0000));
        tbl[tbl.size()-1].cs_n = 1'b1; tbl[tbl.size()-1].ev = 1'b0; tbl[tbl.size()-1].et = C_DES;
        add_des(1, 16'h0000);
        // tRP from cycle 68 expires at 79 only if counting continued with CKE low.
        add_cmd(C_ACT, 4'd4, 14'h0ABC, V_OK, 16'h0010);        // 79
        add_des(10, 16'h0010);
        add_cmd(C_WR, 4'd4, 14'h1433, V_OK, 16'h0000);         // 90: auto-precharge
        add_cmd(C_ACT, 4'd4, 14'h0001, V_TRP, 16'h0010);
        add_cmd(C_ACT, 4'd4, 14'h0002, V_ACT_OPEN, 16'h0010);
        add_des(1, 16'h0010);

        // Reset state.
        #3 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_type", 32'(cmd_type), 32'(C_DES));
        chk("rst_open", 32'(bank_open), 32'd0);
        chk("rst_viol", 32'({viol_valid, viol_code}), 32'd0);
        repeat (2) @(posedge CK_t);
        @(negedge CK_t);
        reset_n = 1'b1;

        // Table: after the edge sampling vector i, outputs show vector i-1.
        for (int i = 0; i <= tbl.size(); i++) begin
            if (i < tbl.size()) drive(tbl[i]);
            else drive(des_vec(16'h0000));
            @(posedge CK_t);
            #1;
            if (i > 0) check_vec(i - 1, tbl[i-1]);
        end

        // Open every bank, leaving bank 4 with tRP pending.
        for (int b = 0; b < 16; b++) begin
            if (b != 4) begin
                drive(cmd_vec(C_ACT, 4'(b), 14'h0300, V_OK, 16'h0000));
                @(posedge CK_t);
            end
        end
        drive(cmd_vec(C_PRE, 4'd4, 14'h0000, V_OK, 16'h0000));
        @(posedge CK_t);
        drive(cmd_vec(C_ACT, 4'd4, 14'h0300, V_OK, 16'h0000));
        @(posedge CK_t);
        drive(des_vec(16'h0000));
        @(posedge CK_t);
        #1;
        chk("pre_rst_open", 32'(bank_open), 32'hFFFF);
        chk("pre_rst_viol", 32'(viol_code), 32'(V_TRP));
        chk("pre_rst_valid", 32'(cmd_valid), 32'd1);

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_type", 32'(cmd_type), 32'(C_DES));
        chk("mid_rst_open", 32'(bank_open), 32'd0);
        chk("mid_rst_viol", 32'({viol_valid, viol_code}), 32'd0);
        chk("mid_rst_row", 32'(cmd_row), 32'd0);

        // First command after reset sees no pending tRP.
        drive(cmd_vec(C_ACT, 4'd4, 14'h0123, V_OK, 16'h0000));
        reset_n = 1'b1;
        @(posedge CK_t);
        drive(des_vec(16'h0000));
        @(posedge CK_t);
        #1;
        chk("post_rst_valid", 32'(cmd_valid), 32'd1);
        chk("post_rst_type", 32'(cmd_type), 32'(C_ACT));
        chk("post_rst_viol", 32'({viol_valid, viol_code}), 32'd0);
        chk("post_rst_open", 32'(bank_open), 32'h0010);
        chk("post_rst_row", 32'(cmd_row), 32'h0123);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_decoder.md
# ddr_cmd_decoder

Memory-side decoder for the DDR4 command/address bus. It samples the command pins on every rising clock edge and decodes each command. It keeps per-bank open/closed state and the open row for all 16 banks, and checks tRCD, tRP and tRAS timing. It sits at the DRAM end of the same bus the controller drives, and it feeds the memory model and the scoreboard with decoded commands and protocol-violation flags.

## Interface
Parameters:
- T_RCD, 11: minimum cycles from ACT to RD/WR in the same bank.
- T_RP, 11: minimum cycles from PRE to ACT in the same bank.
- T_RAS, 28: minimum cycles from ACT to PRE in the same bank.
- CNT_W, 6: width of each per-bank timing counter; must hold max(T_RCD, T_RP, T_RAS).

Ports:
- CK_t  in  1  clock; all logic runs on the rising edge. One clock.
- reset_n  in  1  reset, asynchronous, active-low.
- CKE  in  1  clock enable; when 0, the command is not decoded.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  in  1 each  command pins.
- bg_addr, ba_addr  in  2 each  bank group and bank; bank index = {bg_addr, ba_addr}.
- A17, A13, A12_BC_n, A11, A10_AP  in  1 each  address pins.
- A9_A0  in  10  low address pins.
- cmd_valid  out  1  one-cycle pulse when a decoded non-DES/NOP command is presented.
- cmd_type  out  4  ddr_cmd_e encoding.
- cmd_bank  out  4  bank index.
- cmd_row  out  14  {A13, A12_BC_n, A11, A10_AP, A9_A0}; valid for ACT.
- cmd_col  out  10  A9_A0; valid for RD/WR.
- cmd_ap  out  1  A10_AP for RD/WR/PRE.
- cmd_bc_n  out  1  A12_BC_n for RD/WR.
- bank_open  out  16  per-bank open flag.
- viol_valid  out  1  one-cycle pulse when a protocol violation is detected.
- viol_code  out  3  ddr_viol_e encoding.

## Operation
Decode applies only when CKE=1 and cs_n=0. Otherwise the command is DES and nothing is emitted.
- act_n=0: ACT.
- act_n=1: decode {RAS, CAS, WE}:
  - 000 MRS, 001 REF, 010 PRE (PREA if A10_AP=1), 011 RFU.
  - 100 WR, 101 RD, 110 ZQC, 111 NOP.

Each bank holds: open flag, 14-bit open row, and a down-counter per constraint (rcd_cnt, rp_cnt, ras_cnt). Counters saturate at 0 and decrement every cycle, including while CKE=0.
- **ACT:** legal only if bank closed and rp_cnt=0. Effect: open=1, row latched, rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1.
- **RD/WR:** legal only if bank open and rcd_cnt=0. If cmd_ap=1, the bank closes and rp_cnt=T_RP-1.
- **PRE:** legal only if ras_cnt=0 (PRE to a closed bank is a legal no-op). Effect: open=0, rp_cnt=T_RP-1. PREA applies the same to every bank; the violation check covers only open banks.
- **REF:** legal only if bank_open==0.
- **MRS, ZQC:** decoded and emitted; no bank-state check.

Violation codes (ddr_viol_e), highest priority first:
- V_RFU = 1
- V_ACT_OPEN = 2
- V_TRP = 3
- V_CLOSED = 4
- V_TRCD = 5
- V_TRAS = 6
- V_REF_OPEN = 7

An illegal command is still emitted on cmd_* and still updates bank state, except an ACT to an already-open bank, which leaves the stored row unchanged. A single viol_code is reported per cycle.

## Timing
- **Latency:** 1. Pins sampled on edge N appear on cmd_*/viol_* after edge N+1. bank_open reflects the command from the same edge.
- **Back-to-back commands:** accepted every cycle.
- **Counter reference:** the counter check uses its value before this edge's update. ACT at cycle 0 makes RD legal at cycle T_RCD.
- **Reset:** asynchronous, takes effect immediately. Every output goes to 0: cmd_type=CMD_DES, bank_open=0, viol_code=0, all counters 0. This holds even in the middle of a sequence; the first command after reset sees all banks closed with no timing pending.

## Structure
- Package ddr_cmd_pkg holds:
  - ddr_cmd_e: DES, NOP, ACT, RD, WR, PRE, PREA, REF, MRS, ZQC, RFU.
  - ddr_viol_e.
  - Bank-state struct: open, row, rcd_cnt, rp_cnt, ras_cnt.
  - NUM_BANKS=16.
- Sub-module ddr_bank_tracker: one instance per bank (generate loop). It owns the open flag, row and the three counters, and returns its legality flags to the top-level decoder.

## Test plan
- **Normal ACT/read:** ACT bank 5, row 0x1A3 at cycle 0, then RD col 0x040 at cycle 11 → cmd_valid with type RD, bank 5, no violation; bank_open[5]=1.
- **Early read:** ACT bank 2 at cycle 0, RD bank 2 at cycle 5 → viol_code=V_TRCD; bank stays open.
- **PRE timing and PREA:**
  - PRE bank 2 at 10 cycles after ACT → V_TRAS.
  - PREA at cycle 28 → all banks closed, no violation.
  - ACT at cycle 35 → V_TRP.
- **Refresh with open banks:** REF while bank_open=0x0021 → V_REF_OPEN. REF with all banks closed → clean REF.
- **CKE gating and DES:** CKE=0 with cs_n=0 and ACT pins, or cs_n=1 → no cmd_valid, no state change, counters still expire.
- **Reset mid-operation:** assert reset_n=0 asynchronously with bank_open=0xFFFF → all outputs 0 immediately. After release, an immediate ACT is accepted with no V_TRP.
